tmds_channel_encoder: RTL and testbench

TMDS_CHANNEL_ENCODER -- requirements
Module: tmds_channel_encoder

---
 rtl/tmds_channel_encoder.sv | 183 ++++++++++++++++++
 tb/tb_tmds_channel_encoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b channel encoder with HDMI video preamble/guard-band insertion via a 10-deep lookahead.
// Fixed 12-cycle latency from data_i/ctrl_i/de_i to tmds_o/de_o; free-running, no backpressure.
module tmds_channel_encoder #(
   parameter int CHANNEL  = 0,
   parameter int GUARD_EN = 1
) (
   input  logic       clk_pix,
   input  logic       reset,
   input  logic [7:0] data_i,
   input  logic [1:0] ctrl_i,
   input  logic       de_i,
   output logic [9:0] tmds_o,
   output logic       de_o
);

   typedef enum logic [1:0] {
      CLS_CTRL  = 2'd0,
      CLS_PRE   = 2'd1,
      CLS_GUARD = 2'd2,
      CLS_VIDEO = 2'd3
   } cls_t;

   typedef struct packed {
      logic       de;
      logic [1:0] ctrl;
      logic [7:0] data;
   } smp_t;

   // Entry 10 is the sample being encoded; entries 9..0 are the lookahead at distance 1..10.
   localparam int DEPTH = 11;

   localparam logic [9:0] GUARD_SYM = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;
   localparam logic [9:0] CTRL00    = 10'b1101010100;

   function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
      logic [9:0] s;
      case (c)
         2'b00:   s = 10'b1101010100;
         2'b01:   s = 10'b0010101011;
         2'b10:   s = 10'b0101010100;
         default: s = 10'b1010101011;
      endcase
      return s;
   endfunction

   smp_t r_dl [DEPTH];

   always_ff @(posedge clk_pix) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_dl[i] <= '0;
      end else begin
         r_dl[0] <= '{de: de_i, ctrl: ctrl_i, data: data_i};
         for (int i = 1; i < DEPTH; i++) r_dl[i] <= r_dl[i-1];
      end
   end

   smp_t       w_s;
   logic       w_near;
   logic       w_far;
   cls_t       w_cls;
   logic [1:0] w_ctrl;

   assign w_s = r_dl[DEPTH-1];

   always_comb begin
      w_near = r_dl[9].de | r_dl[8].de;
      w_far  = 1'b0;
      for (int i = 0; i < 8; i++) w_far = w_far | r_dl[i].de;
   end

   // Guard wins over preamble, which also covers blanking gaps shorter than the window.
   always_comb begin
      w_cls  = CLS_CTRL;
      w_ctrl = w_s.ctrl;
      if (w_s.de) begin
         w_cls = CLS_VIDEO;
      end else if (GUARD_EN != 0 && w_near) begin
         w_cls = CLS_GUARD;
      end else if (GUARD_EN != 0 && w_far) begin
         w_cls = CLS_PRE;
         if (CHANNEL == 1)      w_ctrl = 2'b01;
         else if (CHANNEL == 2) w_ctrl = 2'b00;
      end
   end

   logic [3:0] w_n1d;
   logic       w_xnor;
   logic [8:0] w_qm;
   logic [3:0] w_qm_n1;

   always_comb begin
      w_n1d = 4'd0;
      for (int i = 0; i < 8; i++) w_n1d = w_n1d + {3'b000, w_s.data[i]};
      w_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !w_s.data[0]);
      w_qm    = '0;
      w_qm[0] = w_s.data[0];
      for (int i = 1; i < 8; i++) begin
         w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ w_s.data[i]) : (w_qm[i-1] ^ w_s.data[i]);
      end
      w_qm[8] = ~w_xnor;
      w_qm_n1 = 4'd0;
      for (int i = 0; i < 8; i++) w_qm_n1 = w_qm_n1 + {3'b000, w_qm[i]};
   end

   logic [8:0] r_qm;
   logic [3:0] r_n1;
   logic [3:0] r_n0;
   cls_t       r_cls;
   logic [1:0] r_ctrl;

   always_ff @(posedge clk_pix) begin
      if (reset) begin
         r_qm   <= '0;
         r_n1   <= '0;
         r_n0   <= '0;
         r_cls  <= CLS_CTRL;
         r_ctrl <= 2'b00;
      end else begin
         r_qm   <= w_qm;
         r_n1   <= w_qm_n1;
         r_n0   <= 4'd8 - w_qm_n1;
         r_cls  <= w_cls;
         r_ctrl <= w_ctrl;
      end
   end

   logic signed [4:0] r_cnt;
   logic signed [5:0] w_cnt_x;
   logic signed [5:0] w_bal;
   logic signed [5:0] w_cnt_nxt;
   logic [9:0]        w_vid;
   logic              w_pos;
   logic              w_neg;

   // w_bal is N1-N0 of q_m[7:0]; cnt is kept sign-extended while computing the update.
   always_comb begin
      w_cnt_x = {r_cnt[4], r_cnt};
      w_bal   = $signed({2'b00, r_n1}) - $signed({2'b00, r_n0});
      w_pos   = !r_cnt[4] && (r_cnt != 5'sd0) && (r_n1 > r_n0);
      w_neg   = r_cnt[4] && (r_n0 > r_n1);
      if ((r_cnt == 5'sd0) || (r_n1 == r_n0)) begin
         w_vid     = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
         w_cnt_nxt = r_qm[8] ? (w_cnt_x + w_bal) : (w_cnt_x - w_bal);
      end else if (w_pos || w_neg) begin
         w_vid     = {1'b1, r_qm[8], ~r_qm[7:0]};
         w_cnt_nxt = w_cnt_x + (r_qm[8] ? 6'sd2 : 6'sd0) - w_bal;
      end else begin
         w_vid     = {1'b0, r_qm[8], r_qm[7:0]};
         w_cnt_nxt = w_cnt_x - (r_qm[8] ? 6'sd0 : 6'sd2) + w_bal;
      end
   end

   logic [9:0] r_tmds;
   logic       r_de_o;

   always_ff @(posedge clk_pix) begin
      if (reset) begin
         r_tmds <= CTRL00;
         r_de_o <= 1'b0;
         r_cnt  <= 5'sd0;
      end else begin
         r_de_o <= (r_cls == CLS_VIDEO);
         case (r_cls)
            CLS_VIDEO: begin
               r_tmds <= w_vid;
               r_cnt  <= w_cnt_nxt[4:0];
            end
            CLS_GUARD: begin
               r_tmds <= GUARD_SYM;
               r_cnt  <= 5'sd0;
            end
            default: begin
               r_tmds <= ctrl_sym(r_ctrl);
               r_cnt  <= 5'sd0;
            end
         endcase
      end
   end

   assign tmds_o = r_tmds;
   assign de_o   = r_de_o;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Directed bench for tmds_channel_encoder: three parameterisations share one stimulus stream.
module tb_tmds_channel_encoder;

   logic       clk_pix = 1'b0;
   logic       reset;
   logic [7:0] data_i;
   logic [1:0] ctrl_i;
   logic       de_i;
   logic [9:0] tmds0, tmds1, tmdsn;
   logic       de0, de1, den;

   always #5 clk_pix = ~clk_pix;

   tmds_channel_encoder #(.CHANNEL(0), .GUARD_EN(1)) u_dut (
      .clk_pix(clk_pix), .reset(reset), .data_i(data_i), .ctrl_i(ctrl_i),
      .de_i(de_i), .tmds_o(tmds0), .de_o(de0));

   tmds_channel_encoder #(.CHANNEL(1), .GUARD_EN(1)) u_dut_c1 (
      .clk_pix(clk_pix), .reset(reset), .data_i(data_i), .ctrl_i(ctrl_i),
      .de_i(de_i), .tmds_o(tmds1), .de_o(de1));

   tmds_channel_encoder #(.CHANNEL(1), .GUARD_EN(0)) u_dut_ng (
      .clk_pix(clk_pix), .reset(reset), .data_i(data_i), .ctrl_i(ctrl_i),
      .de_i(de_i), .tmds_o(tmdsn), .de_o(den));

   localparam int MAXC = 512;
   localparam int LAT  = 12;

   logic [9:0] o0 [MAXC];
   logic [9:0] o1 [MAXC];
   logic [9:0] on [MAXC];
   logic       d0 [MAXC];
   logic       d1 [MAXC];
   logic       dn [MAXC];
   logic [7:0] in_data [MAXC];
   logic       in_de   [MAXC];

   int cyc      = 0;
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [9:0] act, input logic [9:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%03h expected 0x%03h", tag, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic [1:0] ctrl, input logic de, input logic [7:0] dat);
      reset  = rst;
      ctrl_i = ctrl;
      de_i   = de;
      data_i = dat;
      @(posedge clk_pix);
      #1;
      if (cyc >= MAXC) begin
         $display("FAIL capture_overflow: got %0d expected below %0d", cyc, MAXC);
         $fatal(1, "capture buffer exhausted");
      end
      o0[cyc] = tmds0;  d0[cyc] = de0;
      o1[cyc] = tmds1;  d1[cyc] = de1;
      on[cyc] = tmdsn;  dn[cyc] = den;
      in_data[cyc] = dat;
      in_de[cyc]   = de & ~rst;
      cyc++;
   endtask

   task automatic blank(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 8'h00);
   endtask

   task automatic model_enc(input logic [7:0] d, input int cnt_in, output logic [9:0] sym, output int cnt_out);
      int         n1d;
      int         n1;
      int         n0;
      int         q8;
      logic       use_xnor;
      logic [8:0] qm;
      n1d = 0;
      for (int i = 0; i < 8; i++) n1d += int'(d[i]);
      use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~use_xnor;
      q8 = int'(qm[8]);
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
      n0 = 8 - n1;
      if (cnt_in == 0 || n1 == n0) begin
         sym     = {~qm[8], qm[8], (q8 == 1) ? qm[7:0] : ~qm[7:0]};
         cnt_out = cnt_in + ((q8 == 1) ? (n1 - n0) : (n0 - n1));
      end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
         sym     = {1'b1, qm[8], ~qm[7:0]};
         cnt_out = cnt_in + 2 * q8 + (n0 - n1);
      end else begin
         sym     = {1'b0, qm[8], qm[7:0]};
         cnt_out = cnt_in - 2 * (1 - q8) + (n1 - n0);
      end
   endtask

   logic [9:0] exp_ctrl [4];
   logic [9:0] exp_vid0 [3];

   initial begin
      int base;
      int v;
      int cnt;
      int nxt;
      int disp;
      int maxabs;
      logic [9:0] sym;

      exp_ctrl[0] = 10'h354; exp_ctrl[1] = 10'h0AB;
      exp_ctrl[2] = 10'h154; exp_ctrl[3] = 10'h2AB;
      exp_vid0[0] = 10'h100; exp_vid0[1] = 10'h3FF; exp_vid0[2] = 10'h100;
      reset = 1'b1; ctrl_i = 2'b00; de_i = 1'b0; data_i = 8'h00;

      // Reset held three cycles, then idle blanking must keep emitting ctrl-00.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'b00, 1'b0, 8'h00);
         check_eq($sformatf("rst_tmds%0d", i), o0[cyc-1], 10'h354);
         check_eq($sformatf("rst_de%0d", i), {9'd0, d0[cyc-1]}, 10'd0);
         check_eq($sformatf("rst_tmds_c1_%0d", i), o1[cyc-1], 10'h354);
      end
      for (int i = 0; i < 14; i++) begin
         step(1'b0, 2'b00, 1'b0, 8'h00);
         check_eq($sformatf("idle_tmds%0d", i), o0[cyc-1], 10'h354);
         check_eq($sformatf("idle_de%0d", i), {9'd0, d0[cyc-1]}, 10'd0);
      end

      // Control token mapping, no video anywhere near.
      base = cyc;
      for (int k = 0; k < 4; k++) step(1'b0, 2'(k), 1'b0, 8'h00);
      blank(13);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("ctrl_map%0d", k), o0[base+LAT+k], exp_ctrl[k]);
         check_eq($sformatf("ctrl_map_ng%0d", k), on[base+LAT+k], exp_ctrl[k]);
      end

      // Long blanking into a three-pixel zero run: preamble, guard, DC-balanced video.
      base = cyc;
      blank(20);
      for (int k = 0; k < 3; k++) step(1'b0, 2'b00, 1'b1, 8'h00);
      blank(14);
      v = base + 20;
      check_eq("pre_before_c1", o1[base+LAT+9], 10'h354);
      for (int j = 0; j < 10; j++) begin
         check_eq($sformatf("c1_lead%0d", j), o1[base+LAT+10+j], (j < 8) ? 10'h0AB : 10'h133);
         check_eq($sformatf("ng_lead%0d", j), on[base+LAT+10+j], 10'h354);
      end
      check_eq("c0_pre", o0[base+LAT+10], 10'h354);
      check_eq("c0_guard0", o0[base+LAT+18], 10'h2CC);
      check_eq("c0_guard1", o0[base+LAT+19], 10'h2CC);
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("dc_c0_%0d", k), o0[v+LAT+k], exp_vid0[k]);
         check_eq($sformatf("dc_c1_%0d", k), o1[v+LAT+k], exp_vid0[k]);
         check_eq($sformatf("dc_ng_%0d", k), on[v+LAT+k], exp_vid0[k]);
      end
      check_eq("de_ng_before", {9'd0, dn[v+LAT-1]}, 10'd0);
      check_eq("de_ng_rise", {9'd0, dn[v+LAT]}, 10'd1);
      check_eq("de_c1_before", {9'd0, d1[v+LAT-1]}, 10'd0);
      check_eq("de_c1_rise", {9'd0, d1[v+LAT]}, 10'd1);
      check_eq("de_c1_fall", {9'd0, d1[v+LAT+3]}, 10'd0);
      check_eq("post_video_c1", o1[v+LAT+3], 10'h354);

      // Reset in the middle of a video line discards everything in flight.
      for (int k = 0; k < 5; k++) step(1'b0, 2'b00, 1'b1, 8'hA5);
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 2'b00, 1'b1, 8'hA5);
         check_eq($sformatf("midrst_tmds%0d", k), o0[cyc-1], 10'h354);
         check_eq($sformatf("midrst_de%0d", k), {9'd0, d0[cyc-1]}, 10'd0);
      end
      for (int k = 0; k < 13; k++) begin
         step(1'b0, 2'b00, 1'b0, 8'h00);
         check_eq($sformatf("after_rst_c0_%0d", k), o0[cyc-1], 10'h354);
         check_eq($sformatf("after_rst_c1_%0d", k), o1[cyc-1], 10'h354);
         check_eq($sformatf("after_rst_de%0d", k), {9'd0, d0[cyc-1]}, 10'd0);
      end

      // Random video runs against the reference encoder.
      base = cyc;
      for (int r = 0; r < 3; r++) begin
         blank(15);
         for (int k = 0; k < 30; k++) step(1'b0, 2'b00, 1'b1, 8'($urandom_range(0, 255)));
      end
      blank(14);
      cnt = 0;
      disp = 0;
      maxabs = 0;
      for (int c = base; c + LAT < cyc; c++) begin
         if (in_de[c]) begin
            model_enc(in_data[c], cnt, sym, nxt);
            cnt = nxt;
            check_eq($sformatf("rnd_ng_%0d", c - base), on[c+LAT], sym);
            check_eq($sformatf("rnd_c0_%0d", c - base), o0[c+LAT], sym);
            disp += 2 * $countones(on[c+LAT]) - 10;
            if (disp > maxabs) maxabs = disp;
            if (-disp > maxabs) maxabs = -disp;
         end else begin
            if (c > base && in_de[c-1]) begin
               check_eq($sformatf("disparity_run_end_%0d", c - base), {9'd0, (maxabs <= 10)}, 10'd1);
               disp = 0;
               maxabs = 0;
            end
            cnt = 0;
            check_eq($sformatf("rnd_blank_%0d", c - base), on[c+LAT], 10'h354);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
